cla_seq_adder_ctrl: RTL and testbench

Sequencing controller that performs WIDTH-bit additions by time-multiplexing a single 4-bit carry-lookahead slice over WIDTH/4 nibbles, LSB nibble first. A registered carry links consecutive nibbles. Operands enter and results leave through valid/ready handshakes. The block sits between a request source (CPU/test harness) and result consumer, replacing a wide adder where area matters more than latency.

---
 rtl/cla_seq_pkg.sv | 21 ++
 rtl/cla4_slice.sv | 38 +++
 rtl/cla_seq_adder_ctrl.sv | 142 ++++++++++++++
 tb/tb_cla_seq_adder_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// ============================================================================
// Module      : cla_seq_pkg
// Description : Shared state encoding and slice width for the sequential
//               carry-lookahead adder controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cla4_slice.sv
// ============================================================================
// Module      : cla4_slice
// Description : Combinational 4-bit carry-lookahead adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic       w_c1;
    logic       w_c2;
    logic       w_c3;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every carry is a flat function of g/p and cin, no ripple between bits
    assign w_c1 = w_g[0] | (w_p[0] & cin);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign s = w_p ^ {w_c3, w_c2, w_c1, cin};

endmodule

`default_nettype wire

// File: rtl/cla_seq_adder_ctrl.sv
// ============================================================================
// Module      : cla_seq_adder_ctrl
// Description : WIDTH-bit adder built by iterating one 4-bit CLA slice over
//               the operand nibbles, LSB first, with valid/ready handshakes.
//               Define CLA_SEQ_SUB_EN to add the sub input and ovf output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_seq_adder_ctrl
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / NIBBLE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(NSLICE - 1);

    generate
        if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_width_check
            $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_out_valid;

    logic [3:0]       w_slice_s;
    logic             w_slice_cout;
    logic [WIDTH-1:0] w_sum_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_carry_load;

    cla4_slice u_slice (
        .a    (r_a[3:0]),
        .b    (r_b[3:0]),
        .cin  (r_carry),
        .s    (w_slice_s),
        .cout (w_slice_cout)
    );

    // New nibble enters at the top; after NSLICE shifts nibble 0 sits at the bottom
    assign w_sum_next = (r_sum >> NIBBLE_W) | (WIDTH'(w_slice_s) << (WIDTH - NIBBLE_W));

`ifdef CLA_SEQ_SUB_EN
    logic r_ovf;
    logic w_carry_msb;

    assign w_b_load     = sub ? ~b : b;
    assign w_carry_load = sub ? 1'b1 : cin;
    assign w_carry_msb  = w_slice_s[3] ^ r_a[3] ^ r_b[3];
    assign ovf          = r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if ((r_state == RUN) && (r_cnt == c_last)) begin
            r_ovf <= w_carry_msb ^ w_slice_cout;
        end
    end
`else
    assign w_b_load     = b;
    assign w_carry_load = cin;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a     <= a;
                        r_b     <= w_b_load;
                        r_carry <= w_carry_load;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_next;
                    r_a     <= r_a >> NIBBLE_W;
                    r_b     <= r_b >> NIBBLE_W;
                    r_carry <= w_slice_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_cout      <= w_slice_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (r_state == IDLE);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_cla_seq_adder_ctrl.sv
// ============================================================================
// Module      : tb_cla_seq_adder_ctrl
// Description : Directed self-checking bench for cla_seq_adder_ctrl (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_seq_adder_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             sub;
`ifdef CLA_SEQ_SUB_EN
    logic             ovf;
`endif

    int n_cmp;
    int n_err;

    cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub       (sub),
        .ovf       (ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept one operation, measure latency, check the result, then release it
    task automatic run_op(input vec_t v);
        int lat;
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        sub      = v.sub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        lat      = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        check("latency", lat, 4);
        check("sum", {16'd0, sum}, {16'd0, v.exp_sum});
        check("cout", {31'd0, cout}, {31'd0, v.exp_cout});
`ifdef CLA_SEQ_SUB_EN
        check("ovf", {31'd0, ovf}, {31'd0, v.exp_ovf});
`endif
        check("in_ready_done", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_drop", {31'd0, out_valid}, 32'd0);
        check("in_ready_back", {31'd0, in_ready}, 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        int   lat;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;

        //            a        b        cin   sub   sum      cout  ovf
        vecs.push_back('{16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h0B0B, 16'h0606, 1'b1, 1'b0, 16'h1112, 1'b0, 1'b0});
        vecs.push_back('{16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0009, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});
`ifdef CLA_SEQ_SUB_EN
        vecs.push_back('{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0});
        vecs.push_back('{16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1});
`endif

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i]);
        end

        // Backpressure: result held, new requests ignored while DONE
        v = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 20 && !out_valid) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_latency", lat, 4);
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_sum", {16'd0, sum}, 32'h2345);
            check("bp_cout", {31'd0, cout}, 32'd0);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        check("bp_sum_retained", {16'd0, sum}, 32'h2345);

        // Reset on the second RUN cycle discards the operation
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_sum", {16'd0, sum}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("mid_no_valid", {31'd0, out_valid}, 32'd0);
        end
        check("mid_sum_zero", {16'd0, sum}, 32'd0);

        // Controller still works after the discarded op
        run_op('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
